// File: rtl/layer_featuremap_accumulator.sv
// Per-output-channel reduction stage: sums NUM_CH 3x3 conv results with a
// pipelined adder tree, adds bias, applies optional leaky ReLU and saturates.
module layer_featuremap_accumulator #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    FRAC_BITS   = 8,
    parameter int                    NUM_CH      = 16,
    parameter int                    IMG_SIZE    = 208,
    parameter logic [DATA_WIDTH-1:0] BIAS        = '0,
    parameter int                    ACT_MODE    = 1,
    parameter int                    LEAKY_SHIFT = 3
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         valid_in,
    output logic                         ready_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic                         last_out
);

    localparam int LEVELS = $clog2(NUM_CH);
    localparam int ACC_W  = DATA_WIDTH + LEVELS + 1;
    localparam int PIX    = IMG_SIZE * IMG_SIZE;
    localparam int CNT_W  = (PIX > 1) ? $clog2(PIX) : 1;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(PIX - 1);
    localparam logic signed [ACC_W-1:0] BIAS_EXT =
        {{(ACC_W-DATA_WIDTH){BIAS[DATA_WIDTH-1]}}, BIAS};
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // The fixed-point format is only carried through: integer and fraction
    // bits add identically, so the binary point never moves in this block.
    if (FRAC_BITS >= DATA_WIDTH) begin : g_format_has_no_integer_bits
    end

    // Number of operands present at the output of tree level lvl (lvl 0 = inputs).
    function automatic int nodes(input int lvl);
        return (NUM_CH + (1 << lvl) - 1) >> lvl;
    endfunction

    // Handshake: an input transfers when valid_in & ready_in, an output when
    // valid_out & ready_out. stall = valid_out & ~ready_out freezes every stage
    // (data and valid), so ready_in = ~stall and data_out/last_out hold steady.
    logic stall;

    logic signed [ACC_W-1:0] ext_in [2*NUM_CH];
    logic signed [ACC_W-1:0] tree_q [LEVELS][2*NUM_CH];
    logic [LEVELS-1:0]       tree_v;
    logic signed [ACC_W-1:0] bias_q;
    logic                    bias_v;
    logic signed [ACC_W-1:0] act_d;
    logic [DATA_WIDTH-1:0]   sat_d;
    logic [CNT_W-1:0]        pix_cnt;

    assign stall    = valid_out & ~ready_out;
    assign ready_in = ~stall;
    assign last_out = valid_out & (pix_cnt == CNT_LAST);

    always_comb begin
        for (int k = 0; k < 2*NUM_CH; k++) begin
            ext_in[k] = '0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            ext_in[k] = ACC_W'($signed(data_in[k*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    // Adder tree datapath; an odd leftover operand is carried up unchanged.
    always_ff @(posedge Clk) begin
        if (!stall) begin
            for (int l = 0; l < LEVELS; l++) begin
                for (int i = 0; i < 2*NUM_CH; i++) begin
                    tree_q[l][i] <= '0;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (2*i + 1 < NUM_CH) begin
                    tree_q[0][i] <= ext_in[2*i] + ext_in[2*i+1];
                end else if (2*i < NUM_CH) begin
                    tree_q[0][i] <= ext_in[2*i];
                end
            end
            for (int l = 1; l < LEVELS; l++) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (2*i + 1 < nodes(l)) begin
                        tree_q[l][i] <= tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
                    end else if (2*i < nodes(l)) begin
                        tree_q[l][i] <= tree_q[l-1][2*i];
                    end
                end
            end
            bias_q <= tree_q[LEVELS-1][0] + BIAS_EXT;
        end
    end

    always_comb begin
        act_d = bias_q;
        if (ACT_MODE == 1 && bias_q[ACC_W-1]) begin
            act_d = bias_q >>> LEAKY_SHIFT;
        end
        if (act_d > SAT_MAX) begin
            sat_d = SAT_MAX[DATA_WIDTH-1:0];
        end else if (act_d < SAT_MIN) begin
            sat_d = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_d = act_d[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            tree_v    <= '0;
            bias_v    <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (!stall) begin
            tree_v[0] <= valid_in;
            for (int l = 1; l < LEVELS; l++) begin
                tree_v[l] <= tree_v[l-1];
            end
            bias_v    <= tree_v[LEVELS-1];
            valid_out <= bias_v;
            data_out  <= sat_d;
        end
    end

    // Pixel position of the word currently on data_out within its frame.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pix_cnt <= '0;
        end else if (valid_out && ready_out) begin
            pix_cnt <= (pix_cnt == CNT_LAST) ? '0 : pix_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_layer_featuremap_accumulator.sv
// Bench for layer_featuremap_accumulator: two instances (4-ch leaky with bias,
// 5-ch linear) share one stimulus stream, each with its own expected queue.
module tb_layer_featuremap_accumulator;

    localparam int DW   = 16;
    localparam int PIX1 = 16;
    localparam int PIX2 = 9;

    logic clk = 1'b0;
    logic rst;
    logic valid_in;
    logic [DW-1:0] ch [5];
    logic [4*DW-1:0] data_in1;
    logic [5*DW-1:0] data_in2;
    logic ready_in1, valid_out1, last_out1, ro1;
    logic ready_in2, valid_out2, last_out2, ro2;
    logic [DW-1:0] data_out1, data_out2;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] exp_q2[$];
    int out_idx1, out_idx2, last_cnt1, stall_cnt1;
    logic hold1, hold_l1, hold2, hold_l2;
    logic [DW-1:0] hold_d1, hold_d2;
    bit done;

    assign data_in1 = {ch[3], ch[2], ch[1], ch[0]};
    assign data_in2 = {ch[4], ch[3], ch[2], ch[1], ch[0]};

    layer_featuremap_accumulator #(
        .DATA_WIDTH(16), .FRAC_BITS(8), .NUM_CH(4), .IMG_SIZE(4),
        .BIAS(16'h0100), .ACT_MODE(1), .LEAKY_SHIFT(3)
    ) u_leaky (
        .Clk(clk), .Rst(rst), .data_in(data_in1), .valid_in(valid_in),
        .ready_in(ready_in1), .data_out(data_out1), .valid_out(valid_out1),
        .ready_out(ro1), .last_out(last_out1)
    );

    layer_featuremap_accumulator #(
        .DATA_WIDTH(16), .FRAC_BITS(8), .NUM_CH(5), .IMG_SIZE(3),
        .BIAS(16'h0000), .ACT_MODE(0), .LEAKY_SHIFT(3)
    ) u_linear (
        .Clk(clk), .Rst(rst), .data_in(data_in2), .valid_in(valid_in),
        .ready_in(ready_in2), .data_out(data_out2), .valid_out(valid_out2),
        .ready_out(ro2), .last_out(last_out2)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] ref_px(input int n, input int bias, input bit leaky);
        int s;
        int d;
        s = bias;
        for (int k = 0; k < n; k++) s += int'($signed(ch[k]));
        d = 8;
        if (leaky && s < 0) s = -((-s + d - 1) / d);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[DW-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_accept();
        int n;
        n = 0;
        valid_in = 1'b1;
        while (1) begin
            @(negedge clk);
            if (ready_in1) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got ready_in low for %0d cycles expected accept", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic set_all(input logic [DW-1:0] v);
        for (int k = 0; k < 5; k++) ch[k] = v;
    endtask

    task automatic send_rand();
        for (int k = 0; k < 5; k++) ch[k] = 16'($urandom_range(0, 65535));
        wait_accept();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ro1 = 1'b1;
        while ((exp_q1.size() != 0 || exp_q2.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", exp_q1.size(), exp_q2.size());
        end
    endtask

    // ---------------- scoreboard: expected push on acceptance ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q1.delete();
            exp_q2.delete();
        end else if (valid_in) begin
            if (ready_in1) exp_q1.push_back(ref_px(4, 256, 1'b1));
            if (ready_in2) exp_q2.push_back(ref_px(5, 0, 1'b0));
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst) begin
            out_idx1 = 0;
            hold1 = 1'b0;
        end else begin
            check("ready_in1", 32'(ready_in1), 32'(!(valid_out1 && !ro1)));
            if (hold1) begin
                check("stable_valid1", 32'(valid_out1), 32'd1);
                check("stable_data1", 32'(data_out1), 32'(hold_d1));
                check("stable_last1", 32'(last_out1), 32'(hold_l1));
            end
            if (valid_out1 && !ro1) stall_cnt1++;
            if (valid_out1 && ro1) begin
                if (exp_q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out1: got %0h expected no output", data_out1);
                end else begin
                    e = exp_q1.pop_front();
                    check("data1", 32'(data_out1), 32'(e));
                end
                check("last1", 32'(last_out1), 32'((out_idx1 % PIX1) == PIX1 - 1));
                if (last_out1) last_cnt1++;
                out_idx1++;
            end
            hold1 = valid_out1 && !ro1;
            hold_d1 = data_out1;
            hold_l1 = last_out1;
        end
    end

    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst) begin
            out_idx2 = 0;
            hold2 = 1'b0;
        end else begin
            check("ready_in2", 32'(ready_in2), 32'(!(valid_out2 && !ro2)));
            if (hold2) begin
                check("stable_valid2", 32'(valid_out2), 32'd1);
                check("stable_data2", 32'(data_out2), 32'(hold_d2));
                check("stable_last2", 32'(last_out2), 32'(hold_l2));
            end
            if (valid_out2 && ro2) begin
                if (exp_q2.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out2: got %0h expected no output", data_out2);
                end else begin
                    e = exp_q2.pop_front();
                    check("data2", 32'(data_out2), 32'(e));
                end
                check("last2", 32'(last_out2), 32'((out_idx2 % PIX2) == PIX2 - 1));
                out_idx2++;
            end
            hold2 = valid_out2 && !ro2;
            hold_d2 = data_out2;
            hold_l2 = last_out2;
        end
    end

    // Independent random backpressure on the linear instance.
    initial begin
        ro2 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ro2 = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int vcnt;
        rst = 1'b1;
        valid_in = 1'b0;
        ro1 = 1'b1;
        set_all(16'h0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_valid1", 32'(valid_out1), 32'd0);
        check("rst_data1", 32'(data_out1), 32'd0);
        check("rst_last1", 32'(last_out1), 32'd0);
        check("rst_ready1", 32'(ready_in1), 32'd1);
        check("rst_valid2", 32'(valid_out2), 32'd0);
        check("rst_data2", 32'(data_out2), 32'd0);
        check("rst_last2", 32'(last_out2), 32'd0);
        check("rst_ready2", 32'(ready_in2), 32'd1);

        // Nominal single pixel: latency and value.
        @(posedge clk);
        #1;
        set_all(16'h0100);
        wait_accept();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_out1 && n < 10);
        check("latency1", 32'(n), 32'd4);
        check("nominal_data1", 32'(data_out1), 32'h0500);
        @(negedge clk);
        check("single_pulse1", 32'(valid_out1), 32'd0);

        // Leaky negative and saturation corners.
        @(posedge clk);
        #1;
        set_all(16'hFE00); wait_accept();
        set_all(16'h7FFF); wait_accept();
        set_all(16'h8000); wait_accept();
        drain();

        // Back-to-back stream of 1..10 with a 3-cycle downstream stall.
        stall_cnt1 = 0;
        fork
            begin
                for (int k = 1; k <= 10; k++) begin
                    set_all(16'(k << 8));
                    wait_accept();
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1 ro1 = 1'b0;
                repeat (3) @(posedge clk);
                #1 ro1 = 1'b1;
            end
        join
        drain();
        check("bp_stall_cycles", 32'(stall_cnt1), 32'd3);

        // Frame end: 20 pixels, random backpressure, one last_out.
        pulse_reset();
        last_cnt1 = 0;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 20; k++) send_rand();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 ro1 = ($urandom_range(0, 2) != 0);
                end
                ro1 = 1'b1;
            end
        join
        drain();
        check("frame_outputs", 32'(out_idx1), 32'd20);
        check("frame_lasts", 32'(last_cnt1), 32'd1);

        // Reset with 3 pixels in flight after 7 outputs.
        pulse_reset();
        ro1 = 1'b1;
        for (int k = 0; k < 10; k++) send_rand();
        n = 0;
        while (out_idx1 < 7 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("pre_reset_outputs", 32'(out_idx1), 32'd7);
        check("pre_reset_in_flight", 32'(exp_q1.size()), 32'd3);
        @(posedge clk);
        #1;
        pulse_reset();
        @(negedge clk);
        check("post_reset_valid1", 32'(valid_out1), 32'd0);
        vcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_out1) vcnt++;
        end
        check("flushed_outputs", 32'(vcnt), 32'd0);
        @(posedge clk);
        #1;
        last_cnt1 = 0;
        for (int k = 0; k < 16; k++) send_rand();
        drain();
        check("new_frame_outputs", 32'(out_idx1), 32'd16);
        check("new_frame_lasts", 32'(last_cnt1), 32'd1);

        // Random traffic: idle gaps and random backpressure.
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 ro1 = ($urandom_range(0, 3) != 0);
                end
                ro1 = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_featuremap_accumulator.md
Name: layer_featuremap_accumulator

Overview:
Parametrised per-output-channel reduction stage for the YOLOv3-Tiny conv layers. It takes NUM_CH per-input-channel 3x3 convolution results for one pixel, presented together, and reduces them with a pipelined adder tree. It then adds the channel bias, applies an optional leaky-ReLU, and saturates to DATA_WIDTH. It sits between the Conv2D3x3 bank of a layer_N_featuremap_M instance and the layer output / max-pool. It adds what the current per-layer feature-map blocks lack: cross-channel summation, bias, activation, ready/valid backpressure and a frame-end flag.

Parameters:
DATA_WIDTH, 16, width of each signed fixed-point sample (two's complement)
FRAC_BITS, 8, fractional bits of the fixed-point format (same for inputs, bias, output)
NUM_CH, 16, number of input channels summed (>=2; need not be a power of 2)
IMG_SIZE, 208, output feature-map width = height, used for the pixel counter
BIAS, 0, signed DATA_WIDTH bias added after reduction
ACT_MODE, 1, 0 = linear, 1 = leaky ReLU
LEAKY_SHIFT, 3, negative-slope arithmetic right shift (slope = 2^-LEAKY_SHIFT)

Ports:
Clk  input  1  clock, all logic on rising edge
Rst  input  1  synchronous reset, active-high
data_in  input  NUM_CH*DATA_WIDTH  channel k in bits [k*DATA_WIDTH +: DATA_WIDTH]
valid_in  input  1  data_in valid
ready_in  output  1  block can accept data_in this cycle
data_out  output  DATA_WIDTH  activated, saturated result
valid_out  output  1  data_out valid
ready_out  input  1  downstream accepts data_out
last_out  output  1  qualifies data_out as final pixel of a frame

Behaviour:
- Clock/reset: one clock Clk; Rst is synchronous, active-high.
- Reset values: valid_out=0, data_out=0, last_out=0, all pipeline valid bits=0, pixel counter=0. ready_in=1 in the cycle after reset.
- Widths:
  - LEVELS = clog2(NUM_CH).
  - ACC_W = DATA_WIDTH + LEVELS + 1.
  - Inputs are sign-extended to ACC_W.
  - Odd operand at a tree level is passed through registered, unchanged.
  - No overflow is possible inside the tree.
- Pipeline stages, each registered with its own valid bit:
  - S1..S_LEVELS: adder-tree levels.
  - S_LEVELS+1: add sign-extended BIAS.
  - S_LEVELS+2: activation plus saturation, output register.
  - Latency = LEVELS+2 cycles from accepted input to valid_out with no stall. NUM_CH=16 gives 6; NUM_CH=4 gives 4.
- Activation:
  - ACT_MODE=1 and sum<0: result = sum >>> LEAKY_SHIFT (arithmetic, floor).
  - Otherwise result = sum.
- Saturation: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Handshake:
  - stall = valid_out & ~ready_out.
  - When stall=1, every stage holds its data and valid bits.
  - ready_in = ~stall, combinational.
  - An input is accepted when valid_in & ready_in.
  - An output transfer occurs when valid_out & ready_out.
  - No bubbles are inserted when not stalled; throughput is 1 pixel per cycle.
  - data_out and last_out stay stable while valid_out=1 and ready_out=0.
  - valid_in asserted while ready_in=0 is ignored (not accepted); the source must hold its data.
- Pixel counter:
  - Range 0..IMG_SIZE*IMG_SIZE-1; increments on each output transfer.
  - last_out = valid_out & (count == IMG_SIZE*IMG_SIZE-1).
  - Wraps to 0 on the transfer where last_out=1.
- Reset mid-operation: all in-flight pixels are discarded and the counter clears. The first accepted input after reset is pixel 0 of a new frame.
- Rst has priority over any simultaneous valid_in or ready_out.

Test Plan:
- Nominal sum (NUM_CH=4, DATA_WIDTH=16, FRAC_BITS=8, BIAS=16'h0100, ACT_MODE=1): all channels 16'h0100 (1.0), one valid_in pulse, ready_out=1 -> data_out=16'h0500 (5.0), valid_out high exactly 4 cycles after acceptance, for 1 cycle.
- Leaky negative (same config): all channels 16'hFE00 (-2.0) -> sum -7.0 (-1792) -> data_out=16'hFF20 (-224, i.e. -0.875). With ACT_MODE=0 -> 16'hF900.
- Saturation: all channels 16'h7FFF -> 16'h7FFF. All channels 16'h8000 with ACT_MODE=0, BIAS=0 -> 16'h8000.
- Backpressure: stream 10 consecutive pixels with values 1..10 (integer part), and hold ready_out=0 for 3 cycles mid-stream.
  - ready_in drops in the same cycle valid_out & ~ready_out is high.
  - All 10 outputs appear in order with none lost or duplicated.
  - data_out is stable during the stall.
- Frame end (IMG_SIZE=4): stream 20 pixels -> last_out=1 only on output transfers #16 and (after the wrap) on none of #17-20.
- Reset mid-frame: assert Rst for 1 cycle after 7 outputs with 3 pixels in flight.
  - valid_out=0 on the next cycle; the in-flight pixels never emerge.
  - The next 16 outputs end with last_out on the 16th.
